// File: rtl/serial_adder_ctrl_pkg.sv
// ============================================================================
// serial_adder_ctrl_pkg : shared state encoding and default width
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_adder_ctrl_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_ctrl_pkg

`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
// ============================================================================
// structuralFullAdder : gate-level one-bit full adder cell
// Rev 1.0
// ============================================================================
`default_nettype none

module structuralFullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_axb;
  logic w_ab;
  logic w_cx;

  xor u_x0 (w_axb, i_a, i_b);
  xor u_x1 (o_sum, w_axb, i_cin);
  and u_a0 (w_ab, i_a, i_b);
  and u_a1 (w_cx, w_axb, i_cin);
  or  u_o0 (o_cout, w_ab, w_cx);

endmodule : structuralFullAdder

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// serial_adder_ctrl : bit-serial adder controller around one full-adder cell
// Optional signed-overflow flag enabled by macro SERIAL_ADDER_OVF_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  // Bit 0 of the partial sum would be shifted out unread on the final cycle,
  // so only the upper WIDTH-1 bits are stored.
  logic [WIDTH-1:1]   r_sum_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic               r_ovf;
`endif

  logic               w_fa_s;
  logic               w_fa_c;
  logic [WIDTH-1:0]   w_sum_next;

  structuralFullAdder u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_cin  (r_c),
    .o_sum  (w_fa_s),
    .o_cout (w_fa_c)
  );

  assign w_sum_next = {w_fa_s, r_sum_sh};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_c      <= carryin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next[WIDTH-1:1];
          r_c      <= w_fa_c;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB differs from carry out of it.
            r_ovf   <= r_c ^ w_fa_c;
`endif
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign carryout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

endmodule : serial_adder_ctrl

`default_nettype wire
